model_sequencer: RTL and testbench

MODEL_SEQUENCER -- requirements
Module: model_sequencer

---
 rtl/model_pkg.sv | 37 +++
 rtl/model_desc_decode.sv | 25 ++
 rtl/model_sequencer.sv | 153 +++++++++++++++
 tb/tb_model_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/model_pkg.sv
// Shared definitions for the model descriptor sequencer:
// descriptor field positions, stride and FSM encoding.
package model_pkg;

   localparam int DESC_WORDS = 3;

   localparam int W0_LAST    = 17;
   localparam int W0_ACT_HI  = 16;
   localparam int W0_ACT_LO  = 14;
   localparam int W0_WB_HI   = 10;
   localparam int W0_WB_LO   = 0;
   localparam int WX_LEN_HI  = 17;
   localparam int WX_LEN_LO  = 9;
   localparam int WX_BASE_HI = 8;
   localparam int WX_BASE_LO = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD0,
      S_RD1,
      S_RD2,
      S_CAP,
      S_ISSUE,
      S_DONE
   } state_t;

   typedef struct packed {
      logic       last;
      logic [2:0] act;
      logic [10:0] wbase;
      logic [8:0] in_base;
      logic [8:0] in_len;
      logic [8:0] out_base;
      logic [8:0] out_len;
   } desc_t;

endpackage

// File: rtl/model_desc_decode.sv
// Splits the three captured descriptor words into layer fields.
// Reserved bits of W0 are intentionally ignored.
module model_desc_decode
   import model_pkg::*;
#(
   parameter int MODEL_DATA_WIDTH = 18
) (
   input  logic [MODEL_DATA_WIDTH-1:0] w0,
   input  logic [MODEL_DATA_WIDTH-1:0] w1,
   input  logic [MODEL_DATA_WIDTH-1:0] w2,
   output desc_t                       desc
);

   always_comb begin
      desc          = '0;
      desc.last     = w0[W0_LAST];
      desc.act      = w0[W0_ACT_HI:W0_ACT_LO];
      desc.wbase    = w0[W0_WB_HI:W0_WB_LO];
      desc.in_len   = w1[WX_LEN_HI:WX_LEN_LO];
      desc.in_base  = w1[WX_BASE_HI:WX_BASE_LO];
      desc.out_len  = w2[WX_LEN_HI:WX_LEN_LO];
      desc.out_base = w2[WX_BASE_HI:WX_BASE_LO];
   end

endmodule

// File: rtl/model_sequencer.sv
// Walks a chain of 3-word layer descriptors in model memory
// and issues each layer over a valid/ready handshake.
module model_sequencer
   import model_pkg::*;
#(
   parameter int MODEL_ADDR_WIDTH = 10,
   parameter int MODEL_DATA_WIDTH = 18,
   parameter int MAX_LAYERS       = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        abort,
   input  logic [MODEL_ADDR_WIDTH-1:0] base_addr,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   input  logic                        ld_req,
   input  logic [MODEL_ADDR_WIDTH-1:0] ld_addr,
   input  logic [MODEL_DATA_WIDTH-1:0] ld_data,
   output logic                        ld_ack,
   output logic                        mm_ena,
   output logic                        mm_wea,
   output logic [MODEL_ADDR_WIDTH-1:0] mm_addra,
   output logic [MODEL_DATA_WIDTH-1:0] mm_dla,
   output logic                        mm_enb,
   output logic [MODEL_ADDR_WIDTH-1:0] mm_addrb,
   input  logic [MODEL_DATA_WIDTH-1:0] mm_dob,
   output logic                        lyr_valid,
   input  logic                        lyr_ready,
   output logic                        lyr_last,
   output logic [2:0]                  lyr_act,
   output logic [10:0]                 lyr_wbase,
   output logic [8:0]                  lyr_in_base,
   output logic [8:0]                  lyr_in_len,
   output logic [8:0]                  lyr_out_base,
   output logic [8:0]                  lyr_out_len,
   output logic [5:0]                  lyr_idx
);

   localparam int AW = MODEL_ADDR_WIDTH;
   localparam int IW = 6;

   state_t                state;
   state_t                next;
   logic [AW-1:0]         ptr;
   logic [IW-1:0]         idx;
   logic                  err;
   logic [MODEL_DATA_WIDTH-1:0] w0;
   logic [MODEL_DATA_WIDTH-1:0] w1;
   logic [MODEL_DATA_WIDTH-1:0] w2;
   desc_t                 desc;
   logic                  at_limit;
   logic                  take;

   model_desc_decode #(
      .MODEL_DATA_WIDTH(MODEL_DATA_WIDTH)
   ) u_decode (
      .w0  (w0),
      .w1  (w1),
      .w2  (w2),
      .desc(desc)
   );

   assign busy     = (state != S_IDLE);
   assign ld_ack   = ld_req & ~busy & rst_n;
   assign mm_ena   = ld_ack;
   assign mm_wea   = ld_ack;
   assign mm_addra = ld_addr;
   assign mm_dla   = ld_data;
   assign at_limit = (idx == IW'(MAX_LAYERS - 1));
   assign take     = (state == S_ISSUE) & lyr_ready & ~abort;

   assign error        = err;
   assign lyr_idx      = idx;
   assign lyr_last     = desc.last;
   assign lyr_act      = desc.act;
   assign lyr_wbase    = desc.wbase;
   assign lyr_in_base  = desc.in_base;
   assign lyr_in_len   = desc.in_len;
   assign lyr_out_base = desc.out_base;
   assign lyr_out_len  = desc.out_len;

   always_comb begin
      next      = state;
      mm_enb    = 1'b0;
      mm_addrb  = ptr;
      lyr_valid = 1'b0;
      done      = 1'b0;
      unique case (state)
         S_IDLE: if (start) next = S_RD0;
         S_RD0: begin
            mm_enb = 1'b1;
            next   = S_RD1;
         end
         S_RD1: begin
            mm_enb   = 1'b1;
            mm_addrb = ptr + AW'(1);
            next     = S_RD2;
         end
         S_RD2: begin
            mm_enb   = 1'b1;
            mm_addrb = ptr + AW'(2);
            next     = S_CAP;
         end
         S_CAP: next = S_ISSUE;
         S_ISSUE: begin
            lyr_valid = 1'b1;
            if (lyr_ready) begin
               next = (desc.last | at_limit) ? S_DONE : S_RD0;
            end
         end
         S_DONE: begin
            done = 1'b1;
            next = S_IDLE;
         end
         default: next = S_IDLE;
      endcase
      // abort wins over any handshake in flight
      if (abort && state != S_IDLE) next = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         ptr   <= '0;
         idx   <= '0;
         err   <= 1'b0;
         w0    <= '0;
         w1    <= '0;
         w2    <= '0;
      end else begin
         state <= next;
         if (state == S_IDLE && start) begin
            ptr <= base_addr;
            idx <= '0;
            err <= 1'b0;
         end
         if (state == S_RD1) w0 <= mm_dob;
         if (state == S_RD2) w1 <= mm_dob;
         if (state == S_CAP) w2 <= mm_dob;
         if (take && !desc.last) begin
            if (at_limit) begin
               err <= 1'b1;
            end else begin
               ptr <= ptr + AW'(DESC_WORDS);
               idx <= idx + IW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_model_sequencer.sv
// Self-checking bench: directed descriptor table, hand-written
// corner sequences and randomized chains against a list model.
module tb_model_sequencer;

   localparam int AW = 10;
   localparam int DW = 18;
   localparam int ML = 4;
   localparam int MSZ = 1024;

   logic          clk = 1'b0;
   logic          rst_n, start, abort, ld_req, lyr_ready;
   logic [AW-1:0] base_addr, ld_addr;
   logic [DW-1:0] ld_data;
   logic          busy, done, error, ld_ack;
   logic          mm_ena, mm_wea, mm_enb;
   logic [AW-1:0] mm_addra, mm_addrb;
   logic [DW-1:0] mm_dla, mm_dob;
   logic          lyr_valid, lyr_last;
   logic [2:0]    lyr_act;
   logic [10:0]   lyr_wbase;
   logic [8:0]    lyr_in_base, lyr_in_len, lyr_out_base, lyr_out_len;
   logic [5:0]    lyr_idx;

   always #5 clk = ~clk;

   model_sequencer #(
      .MODEL_ADDR_WIDTH(AW),
      .MODEL_DATA_WIDTH(DW),
      .MAX_LAYERS      (ML)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .start(start), .abort(abort), .base_addr(base_addr),
      .busy(busy), .done(done), .error(error),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
      .ld_ack(ld_ack),
      .mm_ena(mm_ena), .mm_wea(mm_wea), .mm_addra(mm_addra),
      .mm_dla(mm_dla), .mm_enb(mm_enb), .mm_addrb(mm_addrb),
      .mm_dob(mm_dob),
      .lyr_valid(lyr_valid), .lyr_ready(lyr_ready),
      .lyr_last(lyr_last), .lyr_act(lyr_act),
      .lyr_wbase(lyr_wbase), .lyr_in_base(lyr_in_base),
      .lyr_in_len(lyr_in_len), .lyr_out_base(lyr_out_base),
      .lyr_out_len(lyr_out_len), .lyr_idx(lyr_idx)
   );

   // model memory: port A write, port B registered read
   logic [DW-1:0] mem [0:MSZ-1];
   always @(posedge clk) begin
      if (mm_ena && mm_wea) mem[mm_addra] <= mm_dla;
      if (mm_enb) mm_dob <= mem[mm_addrb];
   end

   int rd_q[$];
   always @(negedge clk) if (mm_enb) rd_q.push_back(int'(mm_addrb));

   typedef struct {
      int last, act, wbase, in_base, in_len, out_base, out_len, idx;
   } lyr_t;

   typedef struct {
      int          w0, w1, w2;
      logic [63:0] exp;
   } vec_t;

   int   ref_mem [0:MSZ-1];
   lyr_t exp_l[$];
   int   exp_a[$];
   int   exp_err;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(string nm, logic [63:0] a, logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, a, e);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] pack(lyr_t l);
      return {7'd0, l.last[0], l.act[2:0], l.wbase[10:0],
              l.in_base[8:0], l.in_len[8:0], l.out_base[8:0],
              l.out_len[8:0], l.idx[5:0]};
   endfunction

   function automatic logic [63:0] dut_layer();
      return {7'd0, lyr_last, lyr_act, lyr_wbase, lyr_in_base,
              lyr_in_len, lyr_out_base, lyr_out_len, lyr_idx};
   endfunction

   // list model: follow the chain through the shadow memory
   function automatic void build_expect(int base);
      exp_l.delete();
      exp_a.delete();
      exp_err = 0;
      for (int i = 0; i < ML; i++) begin
         int   a, w0, w1, w2;
         lyr_t l;
         a  = (base + 3 * i) % MSZ;
         w0 = ref_mem[a];
         w1 = ref_mem[(a + 1) % MSZ];
         w2 = ref_mem[(a + 2) % MSZ];
         l.last     = (w0 / 131072) % 2;
         l.act      = (w0 / 16384) % 8;
         l.wbase    = w0 % 2048;
         l.in_base  = w1 % 512;
         l.in_len   = w1 / 512;
         l.out_base = w2 % 512;
         l.out_len  = w2 / 512;
         l.idx      = i;
         exp_l.push_back(l);
         exp_a.push_back(a);
         exp_a.push_back((a + 1) % MSZ);
         exp_a.push_back((a + 2) % MSZ);
         if (l.last != 0) break;
         if (i == ML - 1) exp_err = 1;
      end
   endfunction

   task automatic load(int a, int d);
      ld_req  = 1'b1;
      ld_addr = AW'(a);
      ld_data = DW'(d);
      ref_mem[a] = d;
      #1;
      check("ld_ack", {ld_ack, mm_ena, mm_wea}, 3'b111);
      @(posedge clk);
      #1;
      ld_req = 1'b0;
   endtask

   task automatic run_check(int base, int stall_pct);
      int k, guard;
      build_expect(base);
      rd_q.delete();
      base_addr = AW'(base);
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      guard = 0;
      while (k < exp_l.size() && guard < 300) begin
         lyr_ready = ($urandom_range(99) >= stall_pct);
         if (lyr_valid) begin
            check("layer", dut_layer(), pack(exp_l[k]));
            if (lyr_ready) k++;
         end
         tick();
         guard++;
      end
      lyr_ready = 1'b0;
      check("run_layers", 64'(k), 64'(exp_l.size()));
      check("run_done", {done, lyr_valid}, 2'b10);
      check("run_error", error, exp_err[0]);
      tick();
      check("run_idle", {done, busy, error}, {2'b00, exp_err[0]});
      check("rd_cnt", 64'(rd_q.size()), 64'(exp_a.size()));
      for (int i = 0; i < rd_q.size() && i < exp_a.size(); i++)
         check("rd_addr", 64'(rd_q[i]), 64'(exp_a[i]));
   endtask

   initial begin
      vec_t tbl[4];
      int   base, w;

      tbl[0] = '{32'h28100, 32'h22000, 32'h01500,
                 {7'd0, 1'b1, 3'd2, 11'h100, 9'd0, 9'd272,
                  9'h100, 9'd10, 6'd0}};
      tbl[1] = '{32'h3FFFF, 32'h3FFFF, 32'h3FFFF,
                 {7'd0, 1'b1, 3'd7, 11'h7FF, 9'd511, 9'd511,
                  9'd511, 9'd511, 6'd0}};
      tbl[2] = '{32'h368AB, 32'h00607, 32'h3FE00,
                 {7'd0, 1'b1, 3'd5, 11'h0AB, 9'd7, 9'd3,
                  9'd0, 9'd511, 6'd0}};
      tbl[3] = '{32'h20000, 32'h00000, 32'h001FF,
                 {7'd0, 1'b1, 3'd0, 11'h000, 9'd0, 9'd0,
                  9'd511, 9'd0, 6'd0}};

      for (int i = 0; i < MSZ; i++) ref_mem[i] = 0;
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      ld_req = 1'b0;
      lyr_ready = 1'b0;
      base_addr = '0;
      ld_addr = '0;
      ld_data = '0;
      tick();
      tick();
      check("reset_state",
            {busy, done, error, lyr_valid, lyr_idx, mm_enb, ld_ack},
            12'd0);
      rst_n = 1'b1;
      tick();

      // directed single-layer table, exact latency
      for (int t = 0; t < 4; t++) begin
         load(0, tbl[t].w0);
         load(1, tbl[t].w1);
         load(2, tbl[t].w2);
         lyr_ready = 1'b1;
         base_addr = '0;
         start = 1'b1;
         tick();
         start = 1'b0;
         check("tbl_busy", busy, 1'b1);
         tick();
         tick();
         tick();
         check("tbl_early", lyr_valid, 1'b0);
         tick();
         check("tbl_valid", lyr_valid, 1'b1);
         check("tbl_fields", dut_layer(), tbl[t].exp);
         tick();
         check("tbl_done", {done, lyr_valid}, 2'b10);
         tick();
         check("tbl_end", {done, busy, error}, 3'b000);
         lyr_ready = 1'b0;
      end

      // write and start in the same cycle: new word must be seen
      load(0, 32'h20000);
      load(1, 0);
      ld_req = 1'b1;
      ld_addr = 10'd2;
      ld_data = 18'd16940;
      ref_mem[2] = 16940;
      start = 1'b1;
      base_addr = '0;
      #1;
      check("same_cyc_ack", ld_ack, 1'b1);
      tick();
      ld_req = 1'b0;
      start = 1'b0;
      lyr_ready = 1'b1;
      tick();
      tick();
      tick();
      tick();
      check("same_cyc_fields", dut_layer(),
            {7'd0, 1'b1, 3'd0, 11'd0, 9'd0, 9'd0, 9'd44, 9'd33, 6'd0});
      tick();
      check("same_cyc_done", done, 1'b1);
      tick();
      lyr_ready = 1'b0;

      // two-layer chain at 10 with a 4-cycle stall
      load(10, 32'h04011);
      load(11, 32'h00A01);
      load(12, 32'h00C02);
      load(13, 32'h2C022);
      load(14, 32'h00E03);
      load(15, 32'h01004);
      rd_q.delete();
      base_addr = 10'd10;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      for (int s = 0; s < 5; s++) begin
         check("stall_l0", {lyr_valid, dut_layer()},
               {1'b1, 7'd0, 1'b0, 3'd1, 11'h011, 9'd1, 9'd5,
                9'd2, 9'd6, 6'd0});
         if (s < 4) tick();
      end
      lyr_ready = 1'b1;
      tick();
      lyr_ready = 1'b0;
      check("chain_gap", lyr_valid, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      check("chain_l1", {lyr_valid, dut_layer()},
            {1'b1, 7'd0, 1'b1, 3'd3, 11'h022, 9'd3, 9'd7,
             9'd4, 9'd8, 6'd1});
      lyr_ready = 1'b1;
      tick();
      check("chain_done", done, 1'b1);
      tick();
      lyr_ready = 1'b0;
      check("chain_rd_cnt", 64'(rd_q.size()), 64'd6);
      for (int i = 0; i < 6 && i < rd_q.size(); i++)
         check("chain_rd", 64'(rd_q[i]), 64'(10 + i));

      // address wrap from 1022
      load(1022, 32'h2A123);
      load(1023, 32'h00345);
      load(0, 32'h00678);
      run_check(1022, 0);
      check("wrap_rd",
            {32'(rd_q[0]), 16'(rd_q[1]), 16'(rd_q[2])},
            {32'd1022, 16'd1023, 16'd0});

      // chain with no last bit stops at the layer limit
      for (int j = 0; j < 12; j++)
         load(100 + j, (j * 7919 + 33) % 131072);
      run_check(100, 30);
      check("limit_err_sticky", error, 1'b1);
      rst_n = 1'b0;
      tick();
      check("reset_clears_err", error, 1'b0);
      rst_n = 1'b1;
      tick();

      // abort in ISSUE, then host write
      load(200, 32'h21111);
      load(201, 32'h00222);
      load(202, 32'h00333);
      base_addr = 10'd200;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("abort_pre", lyr_valid, 1'b1);
      abort = 1'b1;
      lyr_ready = 1'b1;
      tick();
      abort = 1'b0;
      lyr_ready = 1'b0;
      check("abort_post", {lyr_valid, busy, done}, 3'b000);
      ld_req = 1'b1;
      ld_addr = 10'd300;
      ld_data = 18'd5;
      ref_mem[300] = 5;
      #1;
      check("abort_ld_ack", ld_ack, 1'b1);
      tick();
      ld_req = 1'b0;
      check("abort_no_done", done, 1'b0);

      // host write refused while reading
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      ld_req = 1'b1;
      ld_addr = 10'd301;
      #1;
      check("busy_ld_ack", {ld_ack, mm_ena}, 2'b00);
      ld_req = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("busy_abort_idle", busy, 1'b0);

      // reset during RD2 overrides everything
      base_addr = 10'd200;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("rd2_addr", {mm_enb, mm_addrb}, {1'b1, 10'd202});
      rst_n = 1'b0;
      start = 1'b1;
      abort = 1'b1;
      ld_req = 1'b1;
      tick();
      check("mid_reset",
            {busy, done, error, lyr_valid, lyr_idx, mm_enb, ld_ack},
            12'd0);
      rst_n = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      ld_req = 1'b0;
      tick();
      run_check(200, 20);

      // randomized chains
      for (int r = 0; r < 20; r++) begin
         base = $urandom_range(MSZ - 1);
         for (int j = 0; j < 15; j++) begin
            w = $urandom_range(131071);
            if ($urandom_range(2) == 0) w = w + 131072;
            load((base + j) % MSZ, w);
         end
         run_check(base, $urandom_range(60));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
